dmem_arbiter: RTL and testbench

- Shares one single-port data memory between the pipelined RISC-V core's data port (CPU) and a DMA/debug loader port (DMA).
- Uses request/ack handshakes, round-robin arbitration and a fixed, parameterised memory latency.
- Drives a stall to the core's memory stage while a CPU access is outstanding.
- Sits between the core's MEM stage, the loader, and the data memory.

---
 rtl/dmem_arbiter.sv | 125 ++++++++++++
 tb/tb_dmem_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the core's MEM
// stage (cpu port) and the DMA/debug loader (dma port). The arbiter alternates
// between the two ports on ties and runs each access through a fixed
// ISSUE -> WAIT x MEM_LAT -> RESP sequence.
module dmem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT);

  logic [1:0]    state;
  logic [3:0]    wait_cnt;
  logic          last_grant;
  logic          owner_q;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] dma_rdata_q;
  logic          grant_dma;

  // Choose who is served next: a lone requester always wins, a tie goes to
  // the port that was not granted last time.
  always_comb begin
    grant_dma = dma_req;
    if (cpu_req && dma_req) begin
      grant_dma = ~last_grant;
    end
  end

  // Transaction sequencer: latch the winner's payload, strobe the memory once,
  // count out the memory latency, capture read data, then pulse the ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= 4'd0;
      last_grant  <= 1'b1;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req || dma_req) begin
            owner_q    <= grant_dma;
            last_grant <= grant_dma;
            we_q       <= grant_dma ? dma_we    : cpu_we;
            addr_q     <= grant_dma ? dma_addr  : cpu_addr;
            wdata_q    <= grant_dma ? dma_wdata : cpu_wdata;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= LAT_LOAD;
          state    <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            if (!we_q) begin
              if (owner_q) begin
                dma_rdata_q <= mem_rdata;
              end else begin
                cpu_rdata_q <= mem_rdata;
              end
            end
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign mem_en    = (state == ISSUE);
  assign mem_we    = (state == ISSUE) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state != IDLE);
  assign owner     = owner_q;
  assign cpu_ack   = (state == RESP) && !owner_q;
  assign dma_ack   = (state == RESP) && owner_q;
  assign cpu_stall = cpu_req && !cpu_ack;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: checks dmem_arbiter against a transaction-level model that
// tracks each grant as a start cycle and derives all outputs from the cycle
// offset. A second instance with MEM_LAT=1 covers the shortest latency.
module tb_dmem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, dma_req, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
  logic          cpu_ack, cpu_stall, dma_ack, mem_en, mem_we, busy, owner;

  logic          b_cpu_req, b_cpu_we, b_dma_req, b_dma_we;
  logic [AW-1:0] b_cpu_addr, b_dma_addr, b_mem_addr;
  logic [DW-1:0] b_cpu_wdata, b_dma_wdata, b_cpu_rdata, b_dma_rdata, b_mem_wdata, b_mem_rdata;
  logic          b_cpu_ack, b_cpu_stall, b_dma_ack, b_mem_en, b_mem_we, b_busy, b_owner;

  dmem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  dmem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(1)) u_dut_lat1 (
    .clk(clk), .reset(reset),
    .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
    .cpu_rdata(b_cpu_rdata), .cpu_ack(b_cpu_ack), .cpu_stall(b_cpu_stall),
    .dma_req(b_dma_req), .dma_we(b_dma_we), .dma_addr(b_dma_addr), .dma_wdata(b_dma_wdata),
    .dma_rdata(b_dma_rdata), .dma_ack(b_dma_ack),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy), .owner(b_owner)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Stimulus staged for the next cycle.
  logic          s_reset, s_cpu_req, s_cpu_we, s_dma_req, s_dma_we;
  logic [AW-1:0] s_cpu_addr, s_dma_addr;
  logic [DW-1:0] s_cpu_wdata, s_dma_wdata, s_mem_rdata;
  logic          s_b_dma_req, s_b_dma_we;
  logic [AW-1:0] s_b_dma_addr;
  logic [DW-1:0] s_b_dma_wdata, s_b_mem_rdata;

  // Transaction-level model of the main instance.
  bit            m_known = 1'b0;
  bit            m_busy, m_owner, m_we, m_last;
  int            m_g;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_cpu_rd, m_dma_rd;
  bit            prev_cpu_ack, prev_dma_ack;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", name, cyc, actual, expected);
    end
  endtask

  task automatic compare_model();
    int d;
    bit e_en, e_ack, e_cpu_ack, e_dma_ack;
    d         = cyc - m_g;
    e_en      = m_busy && (d == 1);
    e_ack     = m_busy && (d == LAT + 2);
    e_cpu_ack = e_ack && !m_owner;
    e_dma_ack = e_ack && m_owner;
    prev_cpu_ack = e_cpu_ack;
    prev_dma_ack = e_dma_ack;
    if (!m_known) return;
    check_output("busy", busy, m_busy);
    check_output("mem_en", mem_en, e_en);
    check_output("mem_we", mem_we, e_en && m_we);
    check_output("cpu_ack", cpu_ack, e_cpu_ack);
    check_output("dma_ack", dma_ack, e_dma_ack);
    check_output("cpu_stall", cpu_stall, cpu_req && !e_cpu_ack);
    check_output("cpu_rdata", cpu_rdata, m_cpu_rd);
    check_output("dma_rdata", dma_rdata, m_dma_rd);
    if (m_busy) begin
      check_output("owner", owner, m_owner);
      check_output("mem_addr", mem_addr, m_addr);
      check_output("mem_wdata", mem_wdata, m_wdata);
    end
  endtask

  task automatic advance_model();
    int d;
    bit sel;
    d = cyc - m_g;
    if (reset) begin
      m_known  = 1'b1;
      m_busy   = 1'b0;
      m_last   = 1'b1;
      m_cpu_rd = '0;
      m_dma_rd = '0;
    end else if (m_busy) begin
      if (d == LAT + 1 && !m_we) begin
        if (m_owner) m_dma_rd = mem_rdata;
        else         m_cpu_rd = mem_rdata;
      end
      if (d == LAT + 2) m_busy = 1'b0;
    end else if (cpu_req || dma_req) begin
      sel     = (cpu_req && dma_req) ? !m_last : dma_req;
      m_owner = sel;
      m_last  = sel;
      m_we    = sel ? dma_we    : cpu_we;
      m_addr  = sel ? dma_addr  : cpu_addr;
      m_wdata = sel ? dma_wdata : cpu_wdata;
      m_busy  = 1'b1;
      m_g     = cyc;
    end
  endtask

  task automatic apply_stimulus();
    @(negedge clk);
    reset       = s_reset;
    cpu_req     = s_cpu_req;
    cpu_we      = s_cpu_we;
    cpu_addr    = s_cpu_addr;
    cpu_wdata   = s_cpu_wdata;
    dma_req     = s_dma_req;
    dma_we      = s_dma_we;
    dma_addr    = s_dma_addr;
    dma_wdata   = s_dma_wdata;
    mem_rdata   = s_mem_rdata;
    b_dma_req   = s_b_dma_req;
    b_dma_we    = s_b_dma_we;
    b_dma_addr  = s_b_dma_addr;
    b_dma_wdata = s_b_dma_wdata;
    b_mem_rdata = s_b_mem_rdata;
    #1;
    compare_model();
    advance_model();
    cyc++;
  endtask

  task automatic idle_stim();
    s_reset = 0; s_cpu_req = 0; s_cpu_we = 0; s_cpu_addr = '0; s_cpu_wdata = '0;
    s_dma_req = 0; s_dma_we = 0; s_dma_addr = '0; s_dma_wdata = '0; s_mem_rdata = '0;
    s_b_dma_req = 0; s_b_dma_we = 0; s_b_dma_addr = '0; s_b_dma_wdata = '0;
    s_b_mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_stim();
    s_reset = 1;
    apply_stimulus();
    apply_stimulus();
    s_reset = 0;
  endtask

  initial begin
    b_cpu_req = 0; b_cpu_we = 0; b_cpu_addr = '0; b_cpu_wdata = '0;
    idle_stim();

    // Reset state and a CPU read of address 100.
    do_reset();
    check_output("reset_busy", busy, 0);
    check_output("reset_cpu_rdata", cpu_rdata, 0);
    check_output("reset_owner", owner, 0);
    for (int t = 0; t <= 5; t++) begin
      s_cpu_req   = (t <= 4);
      s_cpu_we    = 0;
      s_cpu_addr  = 100;
      s_mem_rdata = (t == 3) ? 32'h19 : 32'hFFFF_FFFF;
      apply_stimulus();
      if (t <= 3) check_output("t1_stall", cpu_stall, 1);
      if (t == 1) begin
        check_output("t1_mem_en", mem_en, 1);
        check_output("t1_mem_we", mem_we, 0);
        check_output("t1_mem_addr", mem_addr, 100);
      end
      if (t == 2) check_output("t1_mem_en_off", mem_en, 0);
      if (t == 3) check_output("t1_early_ack", cpu_ack, 0);
      if (t == 4) begin
        check_output("t1_ack", cpu_ack, 1);
        check_output("t1_stall_ack", cpu_stall, 0);
        check_output("t1_rdata", cpu_rdata, 25);
      end
      if (t == 5) check_output("t1_rdata_hold", cpu_rdata, 25);
    end

    // CPU write leaves cpu_rdata untouched.
    do_reset();
    for (int t = 0; t <= 5; t++) begin
      s_cpu_req   = (t <= 4);
      s_cpu_we    = 1;
      s_cpu_addr  = 100;
      s_cpu_wdata = 25;
      s_mem_rdata = 32'hAAAA_5555;
      apply_stimulus();
      if (t == 1) begin
        check_output("t2_mem_en", mem_en, 1);
        check_output("t2_mem_we", mem_we, 1);
        check_output("t2_mem_addr", mem_addr, 100);
        check_output("t2_mem_wdata", mem_wdata, 25);
      end
      if (t == 4) begin
        check_output("t2_ack", cpu_ack, 1);
        check_output("t2_rdata", cpu_rdata, 0);
      end
    end

    // Simultaneous requests from reset: CPU first, then DMA.
    do_reset();
    for (int t = 0; t <= 10; t++) begin
      s_cpu_req   = (t <= 4);
      s_dma_req   = (t <= 9);
      s_cpu_addr  = 32'h10;
      s_dma_addr  = 32'h20;
      s_mem_rdata = 32'(t);
      apply_stimulus();
      if (t == 1) begin
        check_output("t3_cpu_issue", mem_en, 1);
        check_output("t3_cpu_owner", owner, 0);
        check_output("t3_cpu_addr", mem_addr, 32'h10);
      end
      if (t == 4) check_output("t3_cpu_ack", cpu_ack, 1);
      if (t == 5) check_output("t3_bubble", busy, 0);
      if (t == 6) begin
        check_output("t3_dma_issue", mem_en, 1);
        check_output("t3_dma_addr", mem_addr, 32'h20);
      end
      if (t >= 6 && t <= 9) check_output("t3_dma_owner", owner, 1);
      if (t == 9) check_output("t3_dma_ack", dma_ack, 1);
    end

    // Continuous requests from both ports alternate every MEM_LAT+3 cycles.
    do_reset();
    for (int t = 0; t <= 20; t++) begin
      s_cpu_req = (t <= 19);
      s_dma_req = (t <= 19);
      apply_stimulus();
      check_output("t4_cpu_ack", cpu_ack, (t == 4) || (t == 14));
      check_output("t4_dma_ack", dma_ack, (t == 9) || (t == 19));
    end

    // Reset during WAIT of a DMA write aborts it without an ack.
    do_reset();
    for (int t = 0; t <= 5; t++) begin
      s_reset    = (t == 2);
      s_dma_req  = (t <= 2) || (t >= 4);
      s_cpu_req  = (t >= 4);
      s_dma_we   = 1;
      s_dma_addr = 32'h44;
      apply_stimulus();
      if (t == 2 || t == 3) check_output("t5_no_dma_ack", dma_ack, 0);
      if (t == 3) begin
        check_output("t5_busy", busy, 0);
        check_output("t5_mem_en", mem_en, 0);
      end
      if (t == 5) begin
        check_output("t5_regrant_en", mem_en, 1);
        check_output("t5_regrant_owner", owner, 0);
      end
    end

    // Reset after a CPU grant restores CPU priority on the next tie.
    do_reset();
    for (int t = 0; t <= 4; t++) begin
      s_reset   = (t == 2);
      s_cpu_req = 1;
      s_dma_req = 1;
      apply_stimulus();
      if (t == 3) begin
        check_output("t5b_busy", busy, 0);
        check_output("t5b_no_cpu_ack", cpu_ack, 0);
      end
      if (t == 4) begin
        check_output("t5b_en", mem_en, 1);
        check_output("t5b_owner", owner, 0);
      end
    end

    // MEM_LAT=1 instance: DMA read of 0x40.
    do_reset();
    for (int t = 0; t <= 4; t++) begin
      s_b_dma_req   = (t <= 3);
      s_b_dma_we    = 0;
      s_b_dma_addr  = 32'h40;
      s_b_dma_wdata = 32'h0BAD_F00D;
      s_b_mem_rdata = (t == 2) ? 32'hDEAD_BEEF : 32'h1234_5678;
      apply_stimulus();
      if (t == 1) begin
        check_output("t6_mem_en", b_mem_en, 1);
        check_output("t6_mem_we", b_mem_we, 0);
        check_output("t6_mem_addr", b_mem_addr, 32'h40);
        check_output("t6_mem_wdata", b_mem_wdata, 32'h0BAD_F00D);
        check_output("t6_owner", b_owner, 1);
      end
      if (t == 2) check_output("t6_early_ack", b_dma_ack, 0);
      if (t == 3) begin
        check_output("t6_ack", b_dma_ack, 1);
        check_output("t6_rdata", b_dma_rdata, 32'hDEAD_BEEF);
        check_output("t6_cpu_rdata", b_cpu_rdata, 0);
        check_output("t6_cpu_ack", b_cpu_ack, 0);
        check_output("t6_cpu_stall", b_cpu_stall, 0);
      end
      if (t == 4) begin
        check_output("t6_idle", b_busy, 0);
        check_output("t6_rdata_hold", b_dma_rdata, 32'hDEAD_BEEF);
      end
    end

    // Randomised traffic, occasional resets and early request drops.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      s_reset = ($urandom_range(0, 199) == 0);
      if (!s_cpu_req)                   s_cpu_req = 1'($urandom_range(0, 1));
      else if (prev_cpu_ack)            s_cpu_req = 1'($urandom_range(0, 1));
      else if ($urandom_range(0, 63) == 0) s_cpu_req = 0;
      if (!s_dma_req)                   s_dma_req = 1'($urandom_range(0, 1));
      else if (prev_dma_ack)            s_dma_req = 1'($urandom_range(0, 1));
      else if ($urandom_range(0, 63) == 0) s_dma_req = 0;
      s_cpu_we    = 1'($urandom_range(0, 1));
      s_cpu_addr  = $urandom;
      s_cpu_wdata = $urandom;
      s_dma_we    = 1'($urandom_range(0, 1));
      s_dma_addr  = $urandom;
      s_dma_wdata = $urandom;
      s_mem_rdata = $urandom;
      apply_stimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
